xout_window_acc: RTL and testbench
==================================

# xout_window_acc

Windowed statistics stage directly downstream of the generated `GenForEnt` accumulator. It samples the unsigned 8-bit `XOUT` result under a valid/ready handshake, groups the samples into fixed windows of `COUNT` entries, and produces one registered record per window: exact sum, minimum and maximum. The record is handed to the next stage over a valid/ready output port with full backpressure.

## Interface
- `NBITS`, default 8: sample width. Must equal the upstream `XOUT` width.
- `COUNT`, default 4: samples per window. Legal values are 2 to 256.
- `SBITS`, derived localparam: `NBITS + $clog2(COUNT)`. This is the sum width.

Ports (name, direction, width, meaning):
- `CLK`, in, 1: rising-edge clock.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `XIN`, in, NBITS: unsigned sample, wired to upstream `XOUT`.
- `XIN_VALID`, in, 1: the upstream sample is valid this cycle.
- `XIN_READY`, out, 1: the block can accept a sample this cycle.
- `WIN_CLR`, in, 1: synchronous discard of the partial window.
- `SUM`, out, SBITS: sum of the completed window.
- `XMIN`, out, NBITS: minimum of the completed window.
- `XMAX`, out, NBITS: maximum of the completed window.
- `OUT_VALID`, out, 1: the output record is valid.
- `OUT_READY`, in, 1: downstream accepts the record.

## Operation
- A sample is accepted on a rising edge where `XIN_VALID && XIN_READY`. Cycles with `XIN_VALID = 0` are ignored and leave all state unchanged.
- Working registers: `cnt` (0 to COUNT-1), `acc` (SBITS), `mn` (NBITS), `mx` (NBITS).
- State machine:
  - EMPTY (`cnt == 0`): an accepted sample sets `acc = XIN`, `mn = mx = XIN`, `cnt = 1`, and moves to FILL.
  - FILL: an accepted sample sets `acc += XIN`, `mn = min(mn, XIN)`, `mx = max(mx, XIN)`, `cnt += 1`.
  - FILL, last sample (`cnt == COUNT-1`): the accepted sample's contribution goes straight into the output registers `SUM`, `XMIN` and `XMAX`. `OUT_VALID` is set to 1, `cnt` wraps to 0, and the state returns to EMPTY.
- Arithmetic:
  - All values are unsigned. `XIN` is zero-extended to SBITS before addition.
  - `SUM` cannot overflow: `COUNT * (2^NBITS - 1)` fits in SBITS.
- Output register:
  - It holds its value while `OUT_VALID && !OUT_READY`.
  - A handshake (`OUT_VALID && OUT_READY`) clears `OUT_VALID` unless a new window completes on the same edge. In that case the new record is loaded and `OUT_VALID` stays 1 (back-to-back records, no bubble).
- Backpressure:
  - `XIN_READY = !(cnt == COUNT-1 && OUT_VALID && !OUT_READY)`. It is combinational.
  - Non-final samples are always accepted, even while an output record is pending.
  - Only the window-completing sample stalls.
- `WIN_CLR`:
  - On an edge with `WIN_CLR = 1`, `cnt` goes to 0, the state goes to EMPTY, and any sample accepted on that edge is discarded.
  - The output register and `OUT_VALID` are unaffected.
  - `XIN_READY` does not depend on `WIN_CLR`.
- Reset (`RST_N` low, asynchronous, immediate):
  - `cnt`, `acc`, `mn`, `mx`, `SUM`, `XMIN` and `XMAX` go to 0.
  - `OUT_VALID` goes to 0.
  - The state goes to EMPTY, so `XIN_READY` = 1.
  - A partial window in progress is lost.

## Timing
- Latency: `OUT_VALID` and the record appear after the edge that accepts the COUNT-th sample, i.e. they are visible in the next cycle.
- Throughput: one sample per cycle sustained, one record per COUNT cycles, when `OUT_READY` = 1.
- Output stability: `SUM`, `XMIN` and `XMAX` stay stable for every cycle in which `OUT_VALID = 1 && OUT_READY = 0`.
- Output path: all outputs except `XIN_READY` come straight from flops. `XIN_READY` is one comparator plus a 3-input AND.
- Reset release: the first edge after `RST_N` rises may accept a sample.

## Test plan
- **Basic window** (COUNT=4, `OUT_READY`=1): samples 3, 5, 250, 1 on consecutive cycles → one cycle after the 4th, `OUT_VALID`=1 for exactly 1 cycle with `SUM`=259, `XMIN`=1, `XMAX`=250.
- **Width and gaps**: samples 255, 255, 255, 255 with `XIN_VALID` idle cycles between them → `SUM`=1020 (10-bit, no wrap), `XMIN`=`XMAX`=255. The idle cycles do not count as samples.
- **Backpressure**: `OUT_READY`=0 with 8 samples offered back-to-back, values 1 to 8.
  - First record (`SUM`=10, `XMIN`=1, `XMAX`=4) is held stable.
  - Samples 5 to 7 are accepted; `XIN_READY`=0 while sample 8 is offered.
  - Raising `OUT_READY` accepts sample 8 on that edge, and the next record (`SUM`=26, `XMIN`=5, `XMAX`=8) follows with no bubble.
- **`WIN_CLR`**: accept 100, 200, pulse `WIN_CLR`, then accept 10, 20, 30, 40 → a single record with `SUM`=100, `XMIN`=10, `XMAX`=40.
- **Reset mid-operation**:
  - Assert `RST_N`=0 asynchronously after 2 samples with `OUT_VALID`=1 pending → `OUT_VALID`, `SUM`, `XMIN` and `XMAX` read 0 before the next clock edge, and `XIN_READY`=1.
  - After release, 4 fresh samples 7, 7, 7, 7 → `SUM`=28.
- **End-to-end**: `GenForEnt` (count=4) drives `XIN` while `XIN_VALID`=1 → each record matches a reference model of `XOUT`, checked over 100 random A/B pairs.

Source files
------------

// File: rtl/xout_window_acc.sv
// xout_window_acc: windowed sum/min/max of an unsigned sample stream, one record per COUNT samples
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   XIN        unsigned sample (upstream XOUT)
//   XIN_VALID  sample valid
//   XIN_READY  sample can be accepted (combinational)
//   WIN_CLR    synchronous discard of the partial window
//   SUM        sum of the completed window (SBITS wide)
//   XMIN       minimum of the completed window
//   XMAX       maximum of the completed window
//   OUT_VALID  output record valid
//   OUT_READY  downstream accepts the record
module xout_window_acc #(
    parameter int NBITS = 8,
    parameter int COUNT = 4,
    localparam int SBITS = NBITS + $clog2(COUNT)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NBITS-1:0] XIN,
    input  logic             XIN_VALID,
    output logic             XIN_READY,
    input  logic             WIN_CLR,
    output logic [SBITS-1:0] SUM,
    output logic [NBITS-1:0] XMIN,
    output logic [NBITS-1:0] XMAX,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);
    localparam int CBITS = $clog2(COUNT);

    typedef enum logic {EMPTY, FILL} state_t;

    state_t           state;
    logic [CBITS-1:0] cnt;
    logic [SBITS-1:0] acc;
    logic [NBITS-1:0] mn;
    logic [NBITS-1:0] mx;
    logic             last;
    logic             take;
    logic [SBITS-1:0] acc_n;
    logic [NBITS-1:0] mn_n;
    logic [NBITS-1:0] mx_n;

    always_comb begin
        last      = cnt == CBITS'(COUNT - 1);
        // only the window-completing sample can stall, and only behind a held record
        XIN_READY = !(last && OUT_VALID && !OUT_READY);
        take      = XIN_VALID && XIN_READY;
        acc_n     = (state == EMPTY) ? SBITS'(XIN) : acc + SBITS'(XIN);
        mn_n      = (state == EMPTY || XIN < mn) ? XIN : mn;
        mx_n      = (state == EMPTY || XIN > mx) ? XIN : mx;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= EMPTY;
            cnt       <= '0;
            acc       <= '0;
            mn        <= '0;
            mx        <= '0;
            SUM       <= '0;
            XMIN      <= '0;
            XMAX      <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            if (OUT_VALID && OUT_READY)
                OUT_VALID <= 1'b0;
            if (WIN_CLR) begin
                state <= EMPTY;
                cnt   <= '0;
            end else if (take) begin
                if (last) begin
                    // final sample bypasses the working registers straight into the record
                    SUM       <= acc_n;
                    XMIN      <= mn_n;
                    XMAX      <= mx_n;
                    OUT_VALID <= 1'b1;
                    cnt       <= '0;
                    state     <= EMPTY;
                end else begin
                    acc   <= acc_n;
                    mn    <= mn_n;
                    mx    <= mx_n;
                    cnt   <= cnt + CBITS'(1);
                    state <= FILL;
                end
            end
        end
    end
endmodule

// File: tb/tb_xout_window_acc.sv
// tb_xout_window_acc: scoreboard bench for xout_window_acc with directed and random stimulus
module tb_xout_window_acc;
    localparam int NBITS = 8;
    localparam int COUNT = 4;
    localparam int SBITS = NBITS + $clog2(COUNT);

    typedef struct {
        int sum;
        int mn;
        int mx;
    } rec_t;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [NBITS-1:0] XIN = '0;
    logic             XIN_VALID = 1'b0;
    logic             XIN_READY;
    logic             WIN_CLR = 1'b0;
    logic [SBITS-1:0] SUM;
    logic [NBITS-1:0] XMIN;
    logic [NBITS-1:0] XMAX;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;

    int   n_chk = 0;
    int   n_fail = 0;
    rec_t exp_q[$];
    int   win[$];
    bit   m_ov = 0;

    xout_window_acc #(.NBITS(NBITS), .COUNT(COUNT)) dut (
        .CLK(CLK), .RST_N(RST_N), .XIN(XIN), .XIN_VALID(XIN_VALID), .XIN_READY(XIN_READY),
        .WIN_CLR(WIN_CLR), .SUM(SUM), .XMIN(XMIN), .XMAX(XMAX),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference: a window is just a list of accepted samples; a full list becomes a record
    task automatic cycle(input bit v, input int x, input bit r, input bit c);
        bit   m_rdy;
        rec_t rc;
        @(negedge CLK);
        XIN_VALID = v;
        XIN       = NBITS'(x);
        OUT_READY = r;
        WIN_CLR   = c;
        #2;
        m_rdy = !(win.size() == COUNT - 1 && m_ov && !r);
        check("xin_ready", {31'b0, XIN_READY}, {31'b0, m_rdy});
        check("out_valid", {31'b0, OUT_VALID}, {31'b0, m_ov});
        if (m_ov && r) m_ov = 0;
        if (c) win.delete();
        else if (v && m_rdy) begin
            win.push_back(x);
            if (win.size() == COUNT) begin
                rc.sum = 0;
                rc.mn  = 1 << NBITS;
                rc.mx  = -1;
                foreach (win[i]) begin
                    rc.sum += win[i];
                    if (win[i] < rc.mn) rc.mn = win[i];
                    if (win[i] > rc.mx) rc.mx = win[i];
                end
                exp_q.push_back(rc);
                m_ov = 1;
                win.delete();
            end
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(0, 0, r, 0);
    endtask

    task automatic async_reset();
        @(negedge CLK);
        XIN_VALID = 0;
        WIN_CLR   = 0;
        #3;
        RST_N = 0;
        #1;
        check("rst_out_valid", {31'b0, OUT_VALID}, 0);
        check("rst_sum", 32'(SUM), 0);
        check("rst_xmin", 32'(XMIN), 0);
        check("rst_xmax", 32'(XMAX), 0);
        check("rst_xin_ready", {31'b0, XIN_READY}, 1);
        exp_q.delete();
        win.delete();
        m_ov = 0;
        @(negedge CLK);
        RST_N = 1;
    endtask

    // monitor: any presented record must equal the scoreboard head, every cycle it is held
    always @(negedge CLK) begin
        #1;
        if (RST_N && OUT_VALID) begin
            check("record_expected", {31'b0, OUT_VALID}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                check("sum", 32'(SUM), exp_q[0].sum);
                check("xmin", 32'(XMIN), exp_q[0].mn);
                check("xmax", 32'(XMAX), exp_q[0].mx);
                if (OUT_READY) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #12;
        check("init_out_valid", {31'b0, OUT_VALID}, 0);
        check("init_sum", 32'(SUM), 0);
        check("init_xin_ready", {31'b0, XIN_READY}, 1);
        @(negedge CLK);
        RST_N = 1;
        // basic window
        cycle(1, 3, 1, 0); cycle(1, 5, 1, 0); cycle(1, 250, 1, 0); cycle(1, 1, 1, 0);
        idle(3, 1);
        // full-scale samples with idle gaps
        for (int i = 0; i < 4; i++) begin
            cycle(1, 255, 1, 0);
            idle(2, 1);
        end
        idle(2, 1);
        // backpressure: first record held, samples 5..7 accepted, 8 stalls until ready rises
        for (int i = 1; i <= 7; i++) cycle(1, i, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 8, 0, 0);
        cycle(1, 8, 1, 0);
        idle(3, 1);
        // window clear discards the partial window
        cycle(1, 100, 1, 0); cycle(1, 200, 1, 0); cycle(1, 55, 1, 1);
        cycle(1, 10, 1, 0); cycle(1, 20, 1, 0); cycle(1, 30, 1, 0); cycle(1, 40, 1, 0);
        idle(3, 1);
        // reset with a record pending and a partial window
        for (int i = 0; i < 4; i++) cycle(1, 9 + i, 0, 0);
        cycle(1, 60, 0, 0); cycle(1, 61, 0, 0);
        async_reset();
        for (int i = 0; i < 4; i++) cycle(1, 7, 1, 0);
        idle(3, 1);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        idle(4, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
